// File: rtl/gpio_mmio_pkg.sv
// Shared GPIO register map and default window base, also used by the core's
// address decoder.
package gpio_mmio_pkg;

    localparam logic [31:0] GPIO_BASE_ADDR = 32'hFFFF_FF00;

    localparam logic [3:0] GPIO_LED = 4'h0;
    localparam logic [3:0] GPIO_SW  = 4'h4;
    localparam logic [3:0] GPIO_CHG = 4'h8;
    localparam logic [3:0] GPIO_IE  = 4'hC;

    // Word index inside the 16-byte window (Addr[3:2]).
    typedef enum logic [1:0] {
        REG_LED = GPIO_LED[3:2],
        REG_SW  = GPIO_SW[3:2],
        REG_CHG = GPIO_CHG[3:2],
        REG_IE  = GPIO_IE[3:2]
    } gpio_reg_e;

    function automatic gpio_reg_e gpio_reg_index(input logic [1:0] word_addr);
        return gpio_reg_e'(word_addr);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchronizer plus per-bit counter debouncer; a new level is accepted
// only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module gpio_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] change_pulse
);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic             stable_reg;
            logic             differ;
            logic             expired;

            assign differ  = (sync2_reg[gi] != stable_reg);
            assign expired = (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

            // Any cycle that agrees with the stable value restarts the count,
            // which is what rejects short glitches.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (!differ) begin
                    cnt_reg <= '0;
                end else if (expired) begin
                    stable_reg <= sync2_reg[gi];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign stable[gi]       = stable_reg;
            assign change_pulse[gi] = differ && expired;
        end
    endgenerate

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO on the MEM-stage bus: LED outputs, debounced switch
// inputs, sticky per-bit change flags and a level interrupt.
module gpio_mmio
    import gpio_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = GPIO_BASE_ADDR,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          CNT_W           = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    input  logic [7:0]  Switch,
    output logic [7:0]  Led,
    output logic        Irq
);

    logic       sel;
    gpio_reg_e  reg_sel;
    logic       wr_en;

    logic [7:0] led_reg;
    logic [7:0] led_next;
    logic [7:0] ie_reg;
    logic [7:0] ie_next;
    logic [7:0] chg_reg;
    logic [7:0] chg_next;
    logic [7:0] w1c_mask;
    logic       irq_reg;

    logic [7:0] sw_state;
    logic [7:0] change_pulse;

    logic       unused_bits;

    assign sel     = (Addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = gpio_reg_index(Addr[3:2]);
    assign wr_en   = MemWrite && sel;

    assign unused_bits = ^{Addr[1:0], WriteData[31:8]};

    gpio_debounce #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk          (Clk),
        .rst_n        (Rst),
        .din          (Switch),
        .stable       (sw_state),
        .change_pulse (change_pulse)
    );

    always_comb begin
        led_next = led_reg;
        ie_next  = ie_reg;
        w1c_mask = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_LED: led_next = WriteData[7:0];
                REG_CHG: w1c_mask = WriteData[7:0];
                REG_IE:  ie_next  = WriteData[7:0];
                default: ;
            endcase
        end
        // OR-ing the pulse in last makes a same-cycle set beat the clear.
        chg_next = (chg_reg & ~w1c_mask) | change_pulse;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            led_reg <= '0;
            ie_reg  <= '0;
            chg_reg <= '0;
            irq_reg <= 1'b0;
        end else begin
            led_reg <= led_next;
            ie_reg  <= ie_next;
            chg_reg <= chg_next;
            irq_reg <= |(chg_next & ie_next);
        end
    end

    // Reads see the registers before any same-cycle write lands.
    always_comb begin
        ReadData = '0;
        if (MemRead && sel) begin
            case (reg_sel)
                REG_LED: ReadData = {24'h0, led_reg};
                REG_SW:  ReadData = {24'h0, sw_state};
                REG_CHG: ReadData = {24'h0, chg_reg};
                REG_IE:  ReadData = {24'h0, ie_reg};
                default: ReadData = '0;
            endcase
        end
    end

    assign Led = led_reg;
    assign Irq = irq_reg;

endmodule
